// File: rtl/hh_k_step_sequencer.sv
// -----------------------------------------------------------------------------
// hh_k_step_sequencer
//
// Evaluates the Hodgkin-Huxley potassium current
//    I_K = G_K * n^4 * (V - E_K)
// with one shared 16x16 signed multiplier that is stepped through four
// passes (n*n, p*p, p*diff, p*G_K). All arithmetic is signed Q8.8.
// An evaluation is requested by a start pulse or by an internal dt tick
// that fires once every STEP_DIV enabled clock cycles.
//
// Ports:
//    clk      clock
//    rst      synchronous reset, active-low
//    start    single-cycle request for one evaluation
//    auto_en  enables (and, when low, freezes) the internal dt tick counter
//    V        membrane potential, signed Q8.8
//    n        K gating variable, signed Q8.8
//    I_K      potassium current, signed Q8.8, registered, held between runs
//    busy     evaluation in progress
//    done     one-cycle pulse in the cycle I_K shows a new value
//    overrun  sticky: a request was lost (busy with one already pending)
//
// Build option:
//    HH_KSEQ_SAT_EN  defined   -> every multiply result saturates to 16 bits
//                    undefined -> multiply result wraps (product bits [23:8])
//    The V - E_K difference always saturates regardless of this macro.
// -----------------------------------------------------------------------------
module hh_k_step_sequencer #(
   parameter logic signed [15:0] G_K      = 16'sd9216,
   parameter logic signed [15:0] E_K      = -16'sd3072,
   parameter int unsigned        STEP_DIV = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               auto_en,
   input  logic signed [15:0] V,
   input  logic signed [15:0] n,
   output logic signed [15:0] I_K,
   output logic               busy,
   output logic               done,
   output logic               overrun
);

   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SQ1,
      SQ2,
      DV,
      GK
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CW-1:0]      cnt;
   logic               tick;
   logic               req;
   logic               pending;
   logic               accept;

   logic signed [15:0] n_q;
   logic signed [15:0] diff_q;
   logic signed [15:0] p_q;
   logic signed [16:0] diff_w;
   logic signed [15:0] diff_sat;

   logic signed [15:0] mul_a;
   logic signed [15:0] mul_b;
   logic signed [31:0] prod;
   logic signed [23:0] prod_sh;
   logic signed [15:0] mul_r;
   logic               unused_prod_bits;

   // ---------------------------------------------------------------------------
   // dt tick divider: counts only while auto_en is high, holds otherwise
   // ---------------------------------------------------------------------------
   assign tick = auto_en && (cnt == CW'(STEP_DIV - 1));
   assign req  = start || tick;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (auto_en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   assign accept = (state == IDLE) && (req || pending);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SQ1;
         SQ1:     state_nxt = SQ2;
         SQ2:     state_nxt = DV;
         DV:      state_nxt = GK;
         GK:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // ---------------------------------------------------------------------------
   // V - E_K in 17 bits, clamped to 16: overflow shows as bit16 != bit15
   // ---------------------------------------------------------------------------
   assign diff_w = {V[15], V} - {E_K[15], E_K};

   always_comb begin
      if (diff_w[16] != diff_w[15]) begin
         diff_sat = diff_w[16] ? 16'sh8000 : 16'sh7FFF;
      end else begin
         diff_sat = diff_w[15:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Shared multiplier: operands selected by the current pass
   // ---------------------------------------------------------------------------
   always_comb begin
      mul_a = p_q;
      mul_b = G_K;
      case (state)
         SQ1: begin
            mul_a = n_q;
            mul_b = n_q;
         end
         SQ2:     mul_b = p_q;
         DV:      mul_b = diff_q;
         default: ;
      endcase
   end

   assign prod    = mul_a * mul_b;
   // |prod| <= 2^30, so bits [31:8] are the exact arithmetic shift by 8
   assign prod_sh = prod[31:8];

`ifdef HH_KSEQ_SAT_EN
   assign unused_prod_bits = ^prod[7:0];

   always_comb begin
      if (prod_sh[23:15] != {9{prod_sh[23]}}) begin
         mul_r = prod_sh[23] ? 16'sh8000 : 16'sh7FFF;
      end else begin
         mul_r = prod_sh[15:0];
      end
   end
`else
   assign unused_prod_bits = ^{prod[7:0], prod_sh[23:16]};

   always_comb begin
      mul_r = prod_sh[15:0];
   end
`endif

   // ---------------------------------------------------------------------------
   // Datapath registers, result and status
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         n_q     <= '0;
         diff_q  <= '0;
         p_q     <= '0;
         I_K     <= '0;
         done    <= 1'b0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  n_q     <= n;
                  diff_q  <= diff_sat;
                  pending <= 1'b0;
               end
            end
            SQ1, SQ2, DV: p_q <= mul_r;
            GK: begin
               I_K  <= mul_r;
               done <= 1'b1;
            end
            default: ;
         endcase
         // one-deep request buffer while busy; a second request is lost
         if (busy && req) begin
            if (pending) begin
               overrun <= 1'b1;
            end else begin
               pending <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hh_k_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hh_k_step_sequencer
//
// Directed bench for hh_k_step_sequencer (STEP_DIV overridden to 8).
// A transaction-level model computes I_K from V and n with plain integer
// arithmetic and tracks busy/done/pending/overrun as "cycles left" counts;
// a negedge process compares every DUT output against it each cycle.
// Hand-computed literals pin the model on the key vectors.
// -----------------------------------------------------------------------------
module tb_hh_k_step_sequencer;

   localparam int DIV  = 8;
   localparam int GK_M = 9216;
   localparam int EK_M = -3072;

`ifdef HH_KSEQ_SAT_EN
   localparam int EXP_SAT   = 32767;
   localparam int EXP_CLAMP = 32767;
`else
   localparam int EXP_SAT   = -16384;
   localparam int EXP_CLAMP = -36;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic               auto_en = 1'b0;
   logic signed [15:0] V = '0;
   logic signed [15:0] n = '0;
   logic signed [15:0] I_K;
   logic               busy;
   logic               done;
   logic               overrun;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   int exp_t [6] = '{12, 20, 31, 39, 47, 55};

   hh_k_step_sequencer #(.STEP_DIV(DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .auto_en (auto_en),
      .V       (V),
      .n       (n),
      .I_K     (I_K),
      .busy    (busy),
      .done    (done),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference arithmetic
   // ---------------------------------------------------------------------------
   function automatic int mul_m(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      p = p >>> 8;
`ifdef HH_KSEQ_SAT_EN
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
`else
      p = p & 64'hFFFF;
      if (p >= 32768) p = p - 65536;
`endif
      return int'(p);
   endfunction

   function automatic int eval_ik(input int v, input int nv);
      int d;
      int p;
      d = v - EK_M;
      if (d > 32767) d = 32767;
      else if (d < -32768) d = -32768;
      p = mul_m(nv, nv);
      p = mul_m(p, p);
      p = mul_m(p, d);
      return mul_m(p, GK_M);
   endfunction

   // ---------------------------------------------------------------------------
   // Transaction model: an accepted request costs 4 busy cycles, then done
   // ---------------------------------------------------------------------------
   int m_cnt  = 0;
   int m_left = 0;
   int m_res  = 0;
   int m_ik   = 0;
   bit m_pend = 1'b0;
   bit m_ovr  = 1'b0;
   bit m_done = 1'b0;
   logic tick_m;
   logic req_m;

   assign tick_m = auto_en && (m_cnt == DIV - 1);
   assign req_m  = start || tick_m;

   always @(posedge clk) begin
      if (!rst) begin
         m_cnt  <= 0;
         m_left <= 0;
         m_res  <= 0;
         m_ik   <= 0;
         m_pend <= 1'b0;
         m_ovr  <= 1'b0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (auto_en) m_cnt <= tick_m ? 0 : m_cnt + 1;
         if (m_left == 0) begin
            if (req_m || m_pend) begin
               m_res  <= eval_ik(int'(V), int'(n));
               m_left <= 4;
               m_pend <= 1'b0;
            end
         end else begin
            if (req_m) begin
               if (m_pend) m_ovr <= 1'b1;
               else m_pend <= 1'b1;
            end
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_ik   <= m_res;
               m_done <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", int'(busy), (m_left != 0) ? 1 : 0);
         check("cyc_done", int'(done), int'(m_done));
         check("cyc_overrun", int'(overrun), int'(m_ovr));
         check("cyc_IK", int'(I_K), m_ik);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_eval(input int v, input int nv, output int res);
      V = 16'(v);
      n = 16'(nv);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int t = 0; t < 10 && !done; t++) step();
      check("eval_done_seen", int'(done), 1);
      res = int'(I_K);
      step();
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin : stim
      int r;
      int dc;
      int first_d;
      int last_d;
      int tq[$];

      // reset held with requests active
      rst = 1'b0;
      start = 1'b1;
      auto_en = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      step();
      check("rst_IK", int'(I_K), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_overrun", int'(overrun), 0);
      rst = 1'b1;
      start = 1'b0;
      auto_en = 1'b0;
      dc = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done) dc++;
      end
      check("rst_no_done", dc, 0);

      // nominal with exact timing
      V = 16'sd0;
      n = 16'sd128;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         check("nom_busy", int'(busy), 1);
         check("nom_done_low", int'(done), 0);
         step();
      end
      check("nom_done_k5", int'(done), 1);
      check("nom_busy_k5", int'(busy), 0);
      check("nom_IK", int'(I_K), 6912);
      check("model_nom", eval_ik(0, 128), 6912);
      step();
      check("nom_done_one_cycle", int'(done), 0);
      check("nom_IK_hold", int'(I_K), 6912);

      // saturation / clamp corners
      run_eval(25600, 256, r);
      check("sat_IK", r, EXP_SAT);
      check("model_sat", eval_ik(25600, 256), EXP_SAT);
      run_eval(32767, 256, r);
      check("clamp_IK", r, EXP_CLAMP);
      check("model_clamp", eval_ik(32767, 256), EXP_CLAMP);

      // further vectors, model-only expectations
      run_eval(-5000, 200, r);
      check("vec_a", r, eval_ik(-5000, 200));
      run_eval(12000, -90, r);
      check("vec_b", r, eval_ik(12000, -90));
      run_eval(-32768, 32767, r);
      check("vec_c", r, eval_ik(-32768, 32767));
      step();
      step();

      // pending: start at k and k+2 -> done at k+5 and k+10
      V = 16'sd0;
      n = 16'sd128;
      dc = 0;
      first_d = -1;
      last_d = -1;
      for (int i = 0; i <= 14; i++) begin
         if (done) begin
            dc++;
            if (first_d < 0) first_d = i;
            last_d = i;
         end
         start = (i == 0 || i == 2);
         step();
      end
      start = 1'b0;
      check("pend_count", dc, 2);
      check("pend_first", first_d, 5);
      check("pend_second", last_d, 10);
      check("pend_no_overrun", int'(overrun), 0);

      // auto ticks with a 3-cycle pause of auto_en
      for (int i = 0; i <= 56; i++) begin
         if (done) begin
            tq.push_back(i);
            check("auto_IK", int'(I_K), 6912);
         end
         auto_en = !(i >= 20 && i < 23);
         step();
      end
      auto_en = 1'b0;
      check("auto_count", tq.size(), 6);
      for (int i = 0; i < 6 && i < tq.size(); i++) check("auto_time", tq[i], exp_t[i]);
      check("auto_no_overrun", int'(overrun), 0);
      step();
      step();

      // overrun: starts at k, k+2, k+3
      dc = 0;
      for (int i = 0; i <= 14; i++) begin
         if (i == 3) check("ovr_before", int'(overrun), 0);
         if (i == 4) check("ovr_set_k4", int'(overrun), 1);
         if (done) dc++;
         start = (i == 0 || i == 2 || i == 3);
         step();
      end
      start = 1'b0;
      check("ovr_two_done", dc, 2);
      for (int i = 0; i < 5; i++) step();
      check("ovr_sticky", int'(overrun), 1);
      rst = 1'b0;
      step();
      check("ovr_cleared", int'(overrun), 0);
      check("ovr_rst_IK", int'(I_K), 0);
      rst = 1'b1;
      step();
      step();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
